// File: rtl/pll_ctrl_pkg.sv
// Shared types for the ECP5 PLL sequencer: main/step state encodings,
// relock counter width and a small helper used to size the shared counter.
package pll_ctrl_pkg;

  localparam int RELOCK_W = 8;

  typedef enum logic [1:0] {
    MS_PLLRST    = 2'd0,
    MS_WAIT_LOCK = 2'd1,
    MS_STABLE    = 2'd2,
    MS_RUN       = 2'd3
  } main_state_t;

  typedef enum logic [1:0] {
    SS_IDLE  = 2'd0,
    SS_SETUP = 2'd1,
    SS_PULSE = 2'd2,
    SS_HOLD  = 2'd3
  } step_state_t;

  // Largest of three cycle counts; the shared down-counter must hold it.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_ctrl_sync.sv
// Two-flop synchronizer for the asynchronous PLL LOCK signal.
// Both stages clear to 0 so a fresh reset always starts "unlocked".
module pll_ctrl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops before anyone looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_ctrl.sv
// PLL sequencer for the ECP5 EHXPLLL: pulses the PLL reset, waits for and
// qualifies lock, and holds sys_rst_n low until lock has been stable.
// Lock loss or a lock timeout re-sequences and bumps relock_count.
// Optional dynamic phase stepping is built when PLL_CTRL_PHASE_STEP_EN is
// defined; otherwise the step ports exist but are inert.
//
// Step handshake: step_req is a single-cycle request qualified by step_sel
// and step_dir in the same cycle. It is taken only when ready=1 and
// step_busy=0; otherwise it is dropped. step_busy is high from the cycle
// after acceptance until completion, and step_ack pulses for one cycle when
// a step finishes normally (never on abort).
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES   = 1024,
  parameter int unsigned LOCK_TIMEOUT    = 65536,
  parameter int unsigned PLL_RST_CYCLES  = 16,
  parameter int unsigned STEP_LOW_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_locked,
  output logic                pll_rst,
  output logic                sys_rst_n,
  output logic                ready,
  output logic [RELOCK_W-1:0] relock_count,
  input  logic                step_req,
  input  logic                step_dir,
  input  logic [1:0]          step_sel,
  output logic                step_busy,
  output logic                step_ack,
  output logic [1:0]          pll_phasesel,
  output logic                pll_phasedir,
  output logic                pll_phasestep,
  output logic                pll_phaseloadreg
);

  localparam int unsigned CNT_MAX = max3(STABLE_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES);
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  main_state_t         state;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_last;
  logic                locked_s;
  logic [RELOCK_W-1:0] relock_next;

  pll_ctrl_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign cnt_last    = (cnt == CNT_W'(1));
  assign relock_next = (relock_count == '1) ? relock_count : relock_count + 1'b1;

  // Main sequencer: one shared down-counter times the reset pulse, the lock
  // timeout and the stability window; outputs are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= MS_PLLRST;
      cnt          <= CNT_W'(PLL_RST_CYCLES);
      pll_rst      <= 1'b1;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
      relock_count <= '0;
    end else begin
      case (state)
        MS_PLLRST: begin
          if (cnt_last) begin
            state   <= MS_WAIT_LOCK;
            cnt     <= CNT_W'(LOCK_TIMEOUT);
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MS_WAIT_LOCK: begin
          // Lock seen on the timeout cycle still counts as lock.
          if (locked_s) begin
            state <= MS_STABLE;
            cnt   <= CNT_W'(STABLE_CYCLES);
          end else if (cnt_last) begin
            state        <= MS_PLLRST;
            cnt          <= CNT_W'(PLL_RST_CYCLES);
            pll_rst      <= 1'b1;
            relock_count <= relock_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MS_STABLE: begin
          // A dropout restarts qualification without re-pulsing the PLL.
          if (!locked_s) begin
            state <= MS_WAIT_LOCK;
            cnt   <= CNT_W'(LOCK_TIMEOUT);
          end else if (cnt_last) begin
            state     <= MS_RUN;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MS_RUN: begin
          if (!locked_s) begin
            state        <= MS_PLLRST;
            cnt          <= CNT_W'(PLL_RST_CYCLES);
            pll_rst      <= 1'b1;
            sys_rst_n    <= 1'b0;
            ready        <= 1'b0;
            relock_count <= relock_next;
          end
        end
        default: begin
          state     <= MS_PLLRST;
          cnt       <= CNT_W'(PLL_RST_CYCLES);
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_CTRL_PHASE_STEP_EN
  localparam int SCNT_W = $clog2(STEP_LOW_CYCLES + 1);

  step_state_t       step_state;
  logic [SCNT_W-1:0] scnt;

  assign pll_phaseloadreg = 1'b1;

  // Phase-step sequencer: SETUP presents sel/dir, PULSE drives phasestep low,
  // HOLD keeps sel/dir one more cycle. Losing RUN aborts without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_state    <= SS_IDLE;
      scnt          <= '0;
      step_busy     <= 1'b0;
      step_ack      <= 1'b0;
      pll_phasesel  <= 2'd0;
      pll_phasedir  <= 1'b0;
      pll_phasestep <= 1'b1;
    end else begin
      step_ack <= 1'b0;
      if ((step_state != SS_IDLE) && !ready) begin
        step_state    <= SS_IDLE;
        step_busy     <= 1'b0;
        pll_phasestep <= 1'b1;
      end else begin
        case (step_state)
          SS_IDLE: begin
            if (step_req && ready && !step_busy) begin
              step_state   <= SS_SETUP;
              step_busy    <= 1'b1;
              pll_phasesel <= step_sel;
              pll_phasedir <= step_dir;
            end
          end
          SS_SETUP: begin
            step_state    <= SS_PULSE;
            scnt          <= SCNT_W'(STEP_LOW_CYCLES);
            pll_phasestep <= 1'b0;
          end
          SS_PULSE: begin
            if (scnt == SCNT_W'(1)) begin
              step_state    <= SS_HOLD;
              pll_phasestep <= 1'b1;
            end else begin
              scnt <= scnt - 1'b1;
            end
          end
          SS_HOLD: begin
            step_state <= SS_IDLE;
            step_busy  <= 1'b0;
            step_ack   <= 1'b1;
          end
          default: begin
            step_state    <= SS_IDLE;
            step_busy     <= 1'b0;
            pll_phasestep <= 1'b1;
          end
        endcase
      end
    end
  end
`else
  logic unused_step;

  assign step_busy        = 1'b0;
  assign step_ack         = 1'b0;
  assign pll_phasesel     = 2'd0;
  assign pll_phasedir     = 1'b1;
  assign pll_phasestep    = 1'b1;
  assign pll_phaseloadreg = 1'b1;
  assign unused_step      = ^{step_req, step_dir, step_sel, STEP_LOW_CYCLES[0]};
`endif

endmodule
